// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: h/v timing, one-ahead frame-buffer addressing,
// and a two-stage registered pipeline driving hsync/vsync/de/pixel/frame_start.
module vga_scan_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int PIXEL_DEPTH     = 8,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int PIXEL_ADDR_WIDTH = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic                        pxclk,
    input  logic                        rst,
    input  logic                        en,
    output logic [PIXEL_ADDR_WIDTH-1:0] px_addr,
    input  logic [PIXEL_DEPTH-1:0]      px_data,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [PIXEL_DEPTH-1:0]      pixel,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = PIXEL_ADDR_WIDTH;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_BEGIN = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_BEGIN = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Idle (non-pulse) level of hsync/vsync.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    // Stage 0: raster counters and frame-buffer address
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic          active0, hs0, vs0, first0, last0;

    // Stage 1: decoded timing
    logic active1_q, active1_d;
    logic hs1_q, hs1_d;
    logic vs1_q, vs1_d;
    logic first1_q, first1_d;

    // Stage 2: pins
    logic                   de_q, de_d;
    logic [PIXEL_DEPTH-1:0] pixel_q, pixel_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d;

    always_comb begin
        active0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs0     = (h_cnt_q >= H_SYNC_BEGIN) && (h_cnt_q < H_SYNC_END);
        vs0     = (v_cnt_q >= V_SYNC_BEGIN) && (v_cnt_q < V_SYNC_END);
        first0  = (h_cnt_q == '0) && (v_cnt_q == '0);
        last0   = (h_cnt_q == H_ACT_LAST) && (v_cnt_q == V_ACT_LAST);
    end

    always_comb begin
        // NOTE: every _d gets a value on every path so no latch is inferred.
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        addr_cnt_d    = '0;
        active1_d     = 1'b0;
        hs1_d         = 1'b0;
        vs1_d         = 1'b0;
        first1_d      = 1'b0;
        de_d          = 1'b0;
        pixel_d       = '0;
        hsync_d       = SYNC_IDLE;
        vsync_d       = SYNC_IDLE;
        frame_start_d = 1'b0;

        // Scan disabled leaves everything at its reset value, so re-enabling
        // always restarts cleanly at pixel (0,0) with an empty pipeline.
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
                v_cnt_d = v_cnt_q;
            end

            // Blanking holds the address, which already points at the next
            // visible pixel, so no multiply is needed at line starts.
            if (last0) begin
                addr_cnt_d = '0;
            end else if (active0) begin
                addr_cnt_d = addr_cnt_q + AW'(1);
            end else begin
                addr_cnt_d = addr_cnt_q;
            end

            active1_d = active0;
            hs1_d     = hs0;
            vs1_d     = vs0;
            first1_d  = first0;

            // px_data now belongs to the pixel held in stage 1.
            de_d          = active1_q;
            pixel_d       = active1_q ? px_data : '0;
            hsync_d       = hs1_q ^ SYNC_IDLE;
            vsync_d       = vs1_q ^ SYNC_IDLE;
            frame_start_d = first1_q;
        end
    end

    always_ff @(posedge pxclk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            addr_cnt_q    <= '0;
            active1_q     <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            first1_q      <= 1'b0;
            de_q          <= 1'b0;
            pixel_q       <= '0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            active1_q     <= active1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            first1_q      <= first1_d;
            de_q          <= de_d;
            pixel_q       <= pixel_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign px_addr     = addr_cnt_q;
    assign de          = de_q;
    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule
